// File: rtl/friscv_icache_pkg.sv
// Shared types and AXI constants for the instruction-cache line loader.
package friscv_icache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADDR  = 2'd1,
      DATA  = 2'd2,
      WRITE = 2'd3
   } loader_fsm_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/friscv_icache_line_loader_if.sv
// Bundle of the fetcher miss request, AXI4 read channels and cache write port.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; the sender holds valid and payload stable until that edge, and
// ready may change freely.
// Modport master is the line loader, slave is its environment.
interface friscv_icache_line_loader_if #(
   parameter int AXI_ADDR_W    = 32,
   parameter int AXI_ID_W      = 8,
   parameter int AXI_DATA_W    = 32,
   parameter int CACHE_BLOCK_W = 128
);
   logic                     memctrl_arvalid;
   logic                     memctrl_arready;
   logic [AXI_ADDR_W-1:0]    memctrl_araddr;
   logic [2:0]               memctrl_arprot;
   logic [AXI_ID_W-1:0]      memctrl_arid;
   logic                     mem_arvalid;
   logic                     mem_arready;
   logic [AXI_ADDR_W-1:0]    mem_araddr;
   logic [7:0]               mem_arlen;
   logic [2:0]               mem_arsize;
   logic [1:0]               mem_arburst;
   logic [2:0]               mem_arprot;
   logic [AXI_ID_W-1:0]      mem_arid;
   logic                     mem_rvalid;
   logic                     mem_rready;
   logic [AXI_ID_W-1:0]      mem_rid;
   logic [1:0]               mem_rresp;
   logic [AXI_DATA_W-1:0]    mem_rdata;
   logic                     mem_rlast;
   logic                     cache_wen;
   logic [AXI_ADDR_W-1:0]    cache_waddr;
   logic [CACHE_BLOCK_W-1:0] cache_wdata;
   logic                     cache_writing;
   logic                     load_err;

   modport master (
      input  memctrl_arvalid, memctrl_araddr, memctrl_arprot, memctrl_arid,
      output memctrl_arready,
      output mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst,
      output mem_arprot, mem_arid,
      input  mem_arready,
      input  mem_rvalid, mem_rid, mem_rresp, mem_rdata, mem_rlast,
      output mem_rready,
      output cache_wen, cache_waddr, cache_wdata, cache_writing, load_err
   );

   modport slave (
      output memctrl_arvalid, memctrl_araddr, memctrl_arprot, memctrl_arid,
      input  memctrl_arready,
      input  mem_arvalid, mem_araddr, mem_arlen, mem_arsize, mem_arburst,
      input  mem_arprot, mem_arid,
      output mem_arready,
      output mem_rvalid, mem_rid, mem_rresp, mem_rdata, mem_rlast,
      input  mem_rready,
      input  cache_wen, cache_waddr, cache_wdata, cache_writing, load_err
   );

endinterface

// File: rtl/friscv_icache_line_asm.sv
// Beat counter and shift-in line register: each beat enters at the top and
// the line shifts down, so after BEATS beats beat k sits at k*AXI_DATA_W.
module friscv_icache_line_asm #(
   parameter int AXI_DATA_W    = 32,
   parameter int CACHE_BLOCK_W = 128
) (
   input  logic                     clk_i,
   input  logic                     srst_i,
   input  logic                     clr_i,
   input  logic                     beat_i,
   input  logic [AXI_DATA_W-1:0]    data_i,
   output logic [CACHE_BLOCK_W-1:0] line_o,
   output logic                     last_o
);
   localparam int BEATS = CACHE_BLOCK_W / AXI_DATA_W;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   logic [CNT_W-1:0]         cnt_q;
   logic [CACHE_BLOCK_W-1:0] line_q;
   logic [CACHE_BLOCK_W-1:0] line_d;

   generate
      if (BEATS == 1) begin : g_single
         assign line_d = data_i;
      end else begin : g_shift
         assign line_d = {data_i, line_q[CACHE_BLOCK_W-1:AXI_DATA_W]};
      end
   endgenerate

   // Count accepted beats; restart on each new request.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (beat_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Shift beats in; the line is held untouched between bursts.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         line_q <= '0;
      end else if (beat_i) begin
         line_q <= line_d;
      end
   end

   assign line_o = line_q;
   assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/friscv_icache_line_loader.sv
// Instruction-cache line loader: takes one fetcher miss, reads the whole line
// with a single AXI4 INCR burst, then writes it into the cache and pulses
// cache_writing. Optional macro FRISCV_ICACHE_RCHECK_EN adds rlast/rid
// checking of the returned beats.
module friscv_icache_line_loader
   import friscv_icache_pkg::*;
#(
   parameter int AXI_ADDR_W    = 32,
   parameter int AXI_ID_W      = 8,
   parameter int AXI_DATA_W    = 32,
   parameter int CACHE_BLOCK_W = 128
) (
   input  logic                        aclk,
   input  logic                        srst,
   friscv_icache_line_loader_if.master bus,
   output loader_fsm_t                 dbg_state_o
);
   localparam int                    BEATS     = CACHE_BLOCK_W / AXI_DATA_W;
   localparam logic [7:0]            AR_LEN    = 8'(BEATS - 1);
   localparam logic [2:0]            AR_SIZE   = 3'($clog2(AXI_DATA_W / 8));
   localparam logic [AXI_ADDR_W-1:0] LINE_MASK = ~AXI_ADDR_W'(CACHE_BLOCK_W / 8 - 1);

   loader_fsm_t           state_q;
   logic                  req_arready_q;
   logic                  arvalid_q;
   logic                  rready_q;
   logic                  wen_q;
   logic                  writing_q;
   logic                  load_err_q;
   logic                  err_q;
   logic [AXI_ADDR_W-1:0] araddr_q;
   logic [AXI_ADDR_W-1:0] waddr_q;
   logic [7:0]            arlen_q;
   logic [2:0]            arsize_q;
   logic [1:0]            arburst_q;
   logic [2:0]            arprot_q;
   logic [AXI_ID_W-1:0]   arid_q;

   logic req_accept;
   logic beat_en;
   logic last_beat;
   logic beat_err;
   logic err_d;

   assign req_accept = (state_q == IDLE) && bus.memctrl_arvalid;
   assign beat_en    = rready_q && bus.mem_rvalid;
   assign err_d      = err_q | beat_err;

   // Per-beat error: bad response, plus framing/ID checks when enabled.
   always_comb begin
      beat_err = (bus.mem_rresp != AXI_RESP_OKAY);
`ifdef FRISCV_ICACHE_RCHECK_EN
      beat_err = beat_err | (bus.mem_rlast != last_beat) | (bus.mem_rid != arid_q);
`endif
   end

`ifndef FRISCV_ICACHE_RCHECK_EN
   logic unused_rchk;
   assign unused_rchk = ^{bus.mem_rlast, bus.mem_rid};
`endif

   friscv_icache_line_asm #(
      .AXI_DATA_W    (AXI_DATA_W),
      .CACHE_BLOCK_W (CACHE_BLOCK_W)
   ) u_line_asm (
      .clk_i  (aclk),
      .srst_i (srst),
      .clr_i  (req_accept),
      .beat_i (beat_en),
      .data_i (bus.mem_rdata),
      .line_o (bus.cache_wdata),
      .last_o (last_beat)
   );

   // Sequencer: every output is a register updated on the state transition
   // that enters the state where it must be seen. The request ready reads 1
   // out of reset because the FSM itself comes up idle.
   always_ff @(posedge aclk) begin
      if (srst) begin
         state_q       <= IDLE;
         req_arready_q <= 1'b1;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         wen_q         <= 1'b0;
         writing_q     <= 1'b0;
         load_err_q    <= 1'b0;
         err_q         <= 1'b0;
         araddr_q      <= '0;
         waddr_q       <= '0;
         arlen_q       <= '0;
         arsize_q      <= '0;
         arburst_q     <= '0;
         arprot_q      <= '0;
         arid_q        <= '0;
      end else begin
         wen_q      <= 1'b0;
         writing_q  <= 1'b0;
         load_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.memctrl_arvalid) begin
                  araddr_q      <= bus.memctrl_araddr & LINE_MASK;
                  arprot_q      <= bus.memctrl_arprot;
                  arid_q        <= bus.memctrl_arid;
                  arlen_q       <= AR_LEN;
                  arsize_q      <= AR_SIZE;
                  arburst_q     <= AXI_BURST_INCR;
                  err_q         <= 1'b0;
                  req_arready_q <= 1'b0;
                  arvalid_q     <= 1'b1;
                  state_q       <= ADDR;
               end
            end
            ADDR: begin
               if (bus.mem_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (beat_en) begin
                  err_q <= err_d;
                  if (last_beat) begin
                     rready_q   <= 1'b0;
                     writing_q  <= 1'b1;
                     wen_q      <= ~err_d;
                     load_err_q <= err_d;
                     waddr_q    <= araddr_q;
                     state_q    <= WRITE;
                  end
               end
            end
            WRITE: begin
               req_arready_q <= 1'b1;
               state_q       <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.memctrl_arready = req_arready_q;
   assign bus.mem_arvalid     = arvalid_q;
   assign bus.mem_araddr      = araddr_q;
   assign bus.mem_arlen       = arlen_q;
   assign bus.mem_arsize      = arsize_q;
   assign bus.mem_arburst     = arburst_q;
   assign bus.mem_arprot      = arprot_q;
   assign bus.mem_arid        = arid_q;
   assign bus.mem_rready      = rready_q;
   assign bus.cache_wen       = wen_q;
   assign bus.cache_waddr     = waddr_q;
   assign bus.cache_writing   = writing_q;
   assign bus.load_err        = load_err_q;
   assign dbg_state_o         = state_q;

endmodule
